// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier datapath and its controller.
// Holds the FSM state encoding, the default operand width and the counter sizing rule.
package shift_add_mult_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The iteration counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_add_ctrl.sv
// Sequencing for the shift-and-add multiplier: IDLE/RUN/DONE FSM plus iteration counter.
// Emits load/step/finish strobes to the datapath and registered busy/done flags.
module shift_add_ctrl
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic load,
  output logic step,
  output logic finish,
  output logic busy,
  output logic done
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             busy_reg;
  logic             done_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          cnt_next   = CNT_W'(WIDTH);
          state_next = RUN;
        end
      end
      RUN: begin
        step     = 1'b1;
        cnt_next = cnt_reg - CNT_W'(1);
        // The edge that consumes the last multiplier bit also publishes the product.
        if (cnt_reg == CNT_W'(1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // busy/done are decoded from the next state so they are plain flops at the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: captures a/b on start, iterates WIDTH
// times, then presents a 2*WIDTH product with a one-cycle done pulse.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic               load;
  logic               step;
  logic               finish;

  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  shift_add_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .load   (load),
    .step   (step),
    .finish (finish),
    .busy   (busy),
    .done   (done)
  );

  assign addend = q_reg[0] ? m_reg : '0;

  // The carry out of the add is shifted straight into the accumulator MSB on the same
  // edge, so it never needs its own storage: sum[WIDTH] plays the role of C.
  assign sum = {1'b0, acc_reg} + {1'b0, addend};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_reg       <= '0;
      q_reg       <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
    end else begin
      if (load) begin
        m_reg   <= a;
        q_reg   <= b;
        acc_reg <= '0;
      end else if (step) begin
        acc_reg <= sum[WIDTH:1];
        q_reg   <= {sum[0], q_reg[WIDTH-1:1]};
      end
      if (finish) begin
        product_reg <= {sum, q_reg[WIDTH-1:1]};
      end
    end
  end

  assign product = product_reg;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult (WIDTH=4): directed scenarios plus random
// operands checked against plain a*b and the fixed WIDTH-edge latency.
module tb_shift_add_mult;

  localparam int W = 4;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Launches one operation from IDLE and observes it (no comparisons here).
  // Samples are taken 1 time unit after each edge; index 0 is the start-sample edge.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold,
                        output int done_edge, output int done_pulses, output int busy_cycles,
                        output logic [2*W-1:0] prod_at_done, output logic [2*W-1:0] prod_after);
    done_edge    = -1;
    done_pulses  = 0;
    busy_cycles  = 0;
    prod_at_done = 'x;
    prod_after   = 'x;
    a = av;
    b = bv;
    start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 0 && !hold) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        done_edge    = i;
        prod_at_done = product;
      end
      if (!busy && i > 0) begin
        prod_after = product;
        break;
      end
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv);
    int de, dp, bc;
    logic [2*W-1:0] pd, pa;
    logic [2*W-1:0] exp_p;
    exp_p = (2*W)'(int'(av) * int'(bv));
    run_op(av, bv, 1'b0, de, dp, bc, pd, pa);
    checks += 4;
    if (de !== W)      begin errors++; $display("FAIL %s latency: got %0d edges, want %0d", name, de, W); end
    if (dp !== 1)      begin errors++; $display("FAIL %s done_width: got %0d pulses, want 1", name, dp); end
    if (pd !== exp_p)  begin errors++; $display("FAIL %s product: got %0d, want %0d", name, pd, exp_p); end
    if (pa !== exp_p)  begin errors++; $display("FAIL %s product_hold: got %0d, want %0d", name, pa, exp_p); end
    $display("op %s: a=%0d b=%0d product=%0d done_edge=%0d busy_cycles=%0d", name, av, bv, pd, de, bc);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
        errors++;
        $display("FAIL reset_hold: busy=%b done=%b product=%0d, want 0/0/0", busy, done, product);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
        errors++;
        $display("FAIL reset_idle: busy=%b done=%b product=%0d, want 0/0/0", busy, done, product);
      end
    end
    $display("reset: busy=%b done=%b product=%0d", busy, done, product);
  endtask

  task automatic test_basic();
    int de, dp, bc;
    logic [2*W-1:0] pd, pa;
    run_op(4'd5, 4'd3, 1'b0, de, dp, bc, pd, pa);
    checks += 5;
    if (bc !== W + 1) begin errors++; $display("FAIL basic busy_cycles: got %0d, want %0d", bc, W + 1); end
    if (de !== W)     begin errors++; $display("FAIL basic latency: got %0d, want %0d", de, W); end
    if (dp !== 1)     begin errors++; $display("FAIL basic done_width: got %0d, want 1", dp); end
    if (pd !== 8'd15) begin errors++; $display("FAIL basic product: got %0d, want 15", pd); end
    if (pa !== 8'd15) begin errors++; $display("FAIL basic product_hold: got %0d, want 15", pa); end
    $display("op basic: a=5 b=3 product=%0d done_edge=%0d busy_cycles=%0d", pd, de, bc);
  endtask

  task automatic test_corners();
    check_op("max", 4'd15, 4'd15);
    check_op("zero_a", 4'd0, 4'd9);
    check_op("one_b", 4'd9, 4'd1);
  endtask

  task automatic test_ignore_start();
    int first_edge;
    int second_edge;
    logic [2*W-1:0] p1, p2;
    first_edge  = -1;
    second_edge = -1;
    p1 = 'x;
    p2 = 'x;
    a = 4'd6;
    b = 4'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 4'd2;
    b = 4'd2;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done && first_edge < 0) begin
        first_edge = i;
        p1 = product;
        start = 1'b1;
      end else if (done && second_edge < 0) begin
        second_edge = i;
        p2 = product;
        start = 1'b0;
      end
      if (second_edge >= 0 && !busy) break;
    end
    start = 1'b0;
    checks += 4;
    if (p1 !== 8'd42) begin errors++; $display("FAIL ignore first_product: got %0d, want 42", p1); end
    if (first_edge !== W) begin errors++; $display("FAIL ignore first_latency: got %0d, want %0d", first_edge, W); end
    if (p2 !== 8'd4) begin errors++; $display("FAIL ignore second_product: got %0d, want 4", p2); end
    if (second_edge - first_edge !== W + 2) begin
      errors++;
      $display("FAIL ignore second_spacing: got %0d, want %0d", second_edge - first_edge, W + 2);
    end
    $display("op ignore_start: first=%0d at %0d second=%0d at %0d", p1, first_edge, p2, second_edge);
    // Return to a clean IDLE sample point.
    for (int i = 0; i < 10 && busy; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    int saw_done;
    saw_done = 0;
    a = 4'd13;
    b = 4'd11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done++;
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL async_reset immediate: busy=%b done=%b product=%0d, want 0/0/0", busy, done, product);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done++;
    end
    reset = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done++;
    end
    checks++;
    if (saw_done !== 0) begin errors++; $display("FAIL async_reset no_done: got %0d pulses, want 0", saw_done); end
    $display("async_reset: aborted 13*11 mid-run, done pulses=%0d", saw_done);
    check_op("after_reset", 4'd13, 4'd11);
  endtask

  task automatic test_back_to_back();
    int edges[$];
    logic [2*W-1:0] prods[$];
    a = 4'd3;
    b = 4'd4;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges.push_back(i);
        prods.push_back(product);
      end
    end
    start = 1'b0;
    checks++;
    if (edges.size() !== 3) begin errors++; $display("FAIL b2b count: got %0d dones, want 3", edges.size()); end
    for (int k = 0; k < edges.size(); k++) begin
      checks++;
      if (prods[k] !== 8'd12) begin errors++; $display("FAIL b2b product[%0d]: got %0d, want 12", k, prods[k]); end
      if (k > 0) begin
        checks++;
        if (edges[k] - edges[k-1] !== W + 2) begin
          errors++;
          $display("FAIL b2b spacing[%0d]: got %0d, want %0d", k, edges[k] - edges[k-1], W + 2);
        end
      end
      $display("op b2b[%0d]: product=%0d at edge %0d", k, prods[k], edges[k]);
    end
    for (int i = 0; i < 12 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b drain: busy=%b, want 0", busy); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      check_op($sformatf("rand%0d", n), ra, rb);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential shift-and-add unsigned multiplier that consumes operand pairs captured by the 4-bit PIPO operand registers and produces a double-width product after WIDTH iterations. It is the arithmetic stage directly downstream of the operand registers: the PIPO outputs drive `a` and `b`, and a controller pulses `start`. A registered `product` plus a one-cycle `done` pulse is handed to the consumer.

## Interface
- `WIDTH`, default 4, operand width in bits; product is 2*WIDTH bits; legal range 2..16.

- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  multiplicand (unsigned), sampled with `start`.
- `b`  in  WIDTH  multiplier (unsigned), sampled with `start`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse: `product` just updated.
- `product`  out  2*WIDTH  last completed result, held until next completion.

## Operation
- Internal registers: M (WIDTH, multiplicand), Q (WIDTH, multiplier/low product), A (WIDTH, accumulator), C (1, carry), cnt (clog2(WIDTH)+1).
- FSM states: IDLE, RUN, DONE.
- IDLE: `start`=1 at an edge -> M<=a, Q<=b, A<=0, C<=0, cnt<=WIDTH, go RUN. `start`=0 -> stay.
- RUN, each edge: {C,A} = A + (Q[0] ? M : 0) (WIDTH+1-bit sum); then {C,A,Q} shifted right one bit, C<=0; cnt<=cnt-1. If cnt was 1 at this edge: product<={A,Q} post-shift value, go DONE.
- DONE: one cycle; next edge -> IDLE unconditionally.
- `start` in RUN or DONE is ignored (not queued); `a`/`b` changes after capture have no effect.
- Arithmetic unsigned, no overflow possible: max product (2^WIDTH-1)^2 fits 2*WIDTH bits.
- Reset (any time, including mid-RUN): state<=IDLE, M,Q,A,C,cnt<=0, product<=0; in-flight operation discarded, no `done` issued.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0.
- Edge E0 samples `start`=1 in IDLE: `busy`=1 from E0.
- RUN edges E1..E(WIDTH); after E(WIDTH) state=DONE, `done`=1 and new `product` visible for exactly one cycle.
- Edge E(WIDTH+1): state IDLE, `done`=0, `busy`=0; `product` held.
- Latency start-sample to `done`: WIDTH edges; throughput: one op per WIDTH+2 cycles (earliest next `start` sampled at E(WIDTH+1)? no: at E(WIDTH+1) state is still DONE-exiting; next `start` sampled at E(WIDTH+2)).
- `done` and `busy` are registered state decodes; no combinational path from inputs to outputs.
- `product` changes only on the DONE-entry edge or reset.

## Structure
- Shared package (multiplier package used by the whole multiplier datapath): FSM state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default operand width 4.
- One natural sub-module: `shift_add_ctrl` (FSM + iteration counter, outputs load/step/finish strobes); datapath registers and adder stay in `shift_add_mult`.
- Operand capture is internal; the block does not instantiate the PIPO register.

## Test plan
- Reset low for 2 cycles then release, `start`=0 -> `busy`=0, `done`=0, `product`=0 throughout.
- a=5, b=3, pulse `start` -> `busy` high 5 cycles, `done` pulse 4 edges after start sample, `product`=15, held after `done` falls.
- a=15, b=15 -> `product`=225; a=0, b=9 -> `product`=0; a=9, b=1 -> `product`=9 (each checks `done` exactly one cycle wide).
- a=6, b=7 started, then `start`=1 with a=2, b=2 held across RUN/DONE -> first `product`=42; second op begins only at first IDLE sample, yields 4.
- a=13, b=11 started, `reset` pulled low after 2 RUN edges -> outputs 0 immediately (asynchronously), no `done`; after release, a=13, b=11 -> `product`=143.
- Back-to-back: `start` held high continuously with a=3, b=4 -> `done` every WIDTH+2 cycles, `product`=12 each time.
